vga_timing_gen: RTL and testbench

//  Raster timing generator and pixel output stage for the VGA path, clocked by the 25 MHz pixel clock from
//  the video PLL. Produces hsync/vsync/de and pixel coordinates for 640x480@60. Pulls pixels from the

---
 rtl/vga_timing_gen.sv | 271 +++++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator and pixel output stage for the VGA path, running on
// the 25 MHz pixel clock. Generates hsync/vsync/de and pixel coordinates for
// 640x480@60 by default. It pulls pixels from the upstream frame/line buffer
// with a request that is issued one cycle ahead of the registered output. The
// raster is held idle until the PLL reports lock.
//
// Optional feature (compile-time macro):
//   VGA_TEST_PATTERN_EN - adds the test_mode input. When test_mode=1 the
//                         upstream is not read, and eight vertical colour bars
//                         replace pix_data.
//
// Ports
//   clk          in   pixel clock
//   rst          in   asynchronous active-high reset
//   pll_locked   in   PLL lock flag (asynchronous to clk, synchronised here)
//   pix_req      out  pixel request (combinational); the upstream answers in
//                     the same cycle
//   pix_valid    in   upstream pixel present (looked at only when pix_req=1)
//   pix_data     in   {R,G,B} pixel, sampled with pix_valid
//   test_mode    in   colour-bar override (only with VGA_TEST_PATTERN_EN)
//   vga_r/g/b    out  registered colour; 0 outside the active area
//   hsync/vsync  out  registered syncs; active level is SYNC_POL
//   de           out  registered data enable
//   x, y         out  coordinates of the pixel on vga_r/g/b (valid with de)
//   frame_start  out  one-cycle pulse with de for pixel (0,0)
//   underflow    out  sticky flag: a requested pixel was not valid
// -----------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int COORD_W  = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
   output logic               pix_req,
   input  logic               pix_valid,
   input  logic [23:0]        pix_data,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               test_mode,
`endif
   output logic [7:0]         vga_r,
   output logic [7:0]         vga_g,
   output logic [7:0]         vga_b,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               frame_start,
   output logic               underflow
);

   // --------------------------------------------------------------------------
   // Raster geometry, derived from the porch/sync parameters only
   // --------------------------------------------------------------------------
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);

   localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] HS_FIRST   = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);

   localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] VS_FIRST   = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   // --------------------------------------------------------------------------
   // Lock synchroniser: two flops; run is the synchronised lock flag
   // --------------------------------------------------------------------------
   logic lock_meta_reg;
   logic run_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta_reg <= 1'b0;
         run_reg       <= 1'b0;
      end else begin
         lock_meta_reg <= pll_locked;
         run_reg       <= lock_meta_reg;
      end
   end

   // --------------------------------------------------------------------------
   // Stage 0: horizontal / vertical counters
   // The counters are held at zero while run is low. The first cycle with
   // run=1 therefore presents (0,0), and the raster restarts cleanly after a
   // lock loss.
   // --------------------------------------------------------------------------
   logic [H_W-1:0] h_cnt_reg, h_cnt_next;
   logic [V_W-1:0] v_cnt_reg, v_cnt_next;

   always_comb begin
      h_cnt_next = h_cnt_reg;
      v_cnt_next = v_cnt_reg;
      if (!run_reg) begin
         h_cnt_next = '0;
         v_cnt_next = '0;
      end else if (h_cnt_reg == H_LAST) begin
         h_cnt_next = '0;
         if (v_cnt_reg == V_LAST) begin
            v_cnt_next = '0;
         end else begin
            v_cnt_next = v_cnt_reg + 1'b1;
         end
      end else begin
         h_cnt_next = h_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   // --------------------------------------------------------------------------
   // Stage-0 decodes
   // --------------------------------------------------------------------------
   logic active_s0;     // current counter position is inside the visible area
   logic hs_act_s0;     // current h position lies in the hsync pulse
   logic vs_act_s0;     // current v position lies in the vsync pulse
   logic origin_s0;     // current position is pixel (0,0)
   logic pattern_sel;   // colour bars replace upstream pixels

   assign active_s0 = run_reg && (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
   assign hs_act_s0 = (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST);
   assign vs_act_s0 = (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST);
   assign origin_s0 = (h_cnt_reg == '0) && (v_cnt_reg == '0);

`ifdef VGA_TEST_PATTERN_EN
   assign pattern_sel = test_mode;
`else
   assign pattern_sel = 1'b0;
`endif

   // In pattern mode the upstream must not see a request. Without a request
   // it is not popped, and no underflow can be recorded.
   assign pix_req = active_s0 && !pattern_sel;

   // --------------------------------------------------------------------------
   // Pixel colour selection for stage 1
   // --------------------------------------------------------------------------
   logic [23:0] rgb_next;

`ifdef VGA_TEST_PATTERN_EN
   // Eight equal-width vertical bars across the active line. With the
   // canonical ordering (white, yellow, cyan, green, magenta, red, blue,
   // black), each channel is the inverse of one bar-index bit:
   // R = ~idx[1], G = ~idx[2], B = ~idx[0].
   localparam int BAR_W = H_ACTIVE / 8;

   logic [2:0]  bar_idx;
   logic [2:0]  chan_on;    // {R, G, B} channel enables for the current bar
   logic [23:0] bar_rgb;

   assign bar_idx = 3'(h_cnt_reg / H_W'(BAR_W));
   assign chan_on = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};

   for (genvar gi = 0; gi < 3; gi++) begin : g_bar_chan
      assign bar_rgb[gi*8 +: 8] = {8{chan_on[gi]}};
   end
`endif

   always_comb begin
      rgb_next = 24'h000000;
      if (pix_req && pix_valid) begin
         rgb_next = pix_data;
      end
`ifdef VGA_TEST_PATTERN_EN
      if (pattern_sel && active_s0) begin
         rgb_next = bar_rgb;
      end
`endif
   end

   // --------------------------------------------------------------------------
   // Stage 1: registered outputs, one cycle behind the stage-0 counters.
   // The syncs are decoded from stage 0 and registered here, which keeps them
   // aligned with de. While run is low everything except underflow is forced
   // back to its reset value.
   // --------------------------------------------------------------------------
   logic               de_reg;
   logic               hsync_reg;
   logic               vsync_reg;
   logic [COORD_W-1:0] x_reg;
   logic [COORD_W-1:0] y_reg;
   logic [23:0]        rgb_reg;
   logic               frame_start_reg;
   logic               underflow_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_reg          <= 1'b0;
         hsync_reg       <= ~SYNC_POL;
         vsync_reg       <= ~SYNC_POL;
         x_reg           <= '0;
         y_reg           <= '0;
         rgb_reg         <= 24'h000000;
         frame_start_reg <= 1'b0;
      end else if (!run_reg) begin
         de_reg          <= 1'b0;
         hsync_reg       <= ~SYNC_POL;
         vsync_reg       <= ~SYNC_POL;
         x_reg           <= '0;
         y_reg           <= '0;
         rgb_reg         <= 24'h000000;
         frame_start_reg <= 1'b0;
      end else begin
         de_reg    <= active_s0;
         hsync_reg <= hs_act_s0 ? SYNC_POL : ~SYNC_POL;
         vsync_reg <= vs_act_s0 ? SYNC_POL : ~SYNC_POL;
         // Coordinates track the visible area even in pattern mode. They hold
         // their last value during blanking.
         if (active_s0) begin
            x_reg <= COORD_W'(h_cnt_reg);
            y_reg <= COORD_W'(v_cnt_reg);
         end
         rgb_reg         <= rgb_next;
         // Tied to an actual request, so the pulse marks the first pixel that
         // was pulled from upstream.
         frame_start_reg <= pix_req && origin_s0;
      end
   end

   // Sticky underflow: only rst clears it. A lock loss does not clear it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underflow_reg <= 1'b0;
      end else if (pix_req && !pix_valid) begin
         underflow_reg <= 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Output mapping
   // --------------------------------------------------------------------------
   assign vga_r       = rgb_reg[23:16];
   assign vga_g       = rgb_reg[15:8];
   assign vga_b       = rgb_reg[7:0];
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign de          = de_reg;
   assign x           = x_reg;
   assign y           = y_reg;
   assign frame_start = frame_start_reg;
   assign underflow   = underflow_reg;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Scoreboard bench for vga_timing_gen. The stimulus process drives one cycle
// at a time. For each cycle it derives the expected pix_req and the expected
// registered outputs from a position model: elapsed cycles since run rose,
// split into h/v with div/mod. It pushes both into queues. A separate monitor
// pops and compares them on every cycle, and it also evaluates named one-off
// checks that the stimulus queues.
// The raster geometry is scaled down so that several whole frames fit into a
// short run. The porch/sync proportions keep the same structure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_timing_gen;

   localparam int HA  = 64, HFP = 4, HS = 8, HBP = 6;
   localparam int VA  = 24, VFP = 2, VS = 2, VBP = 3;
   localparam int HT  = HA + HFP + HS + HBP;   // 82
   localparam int VT  = VA + VFP + VS + VBP;   // 31
   localparam int FRAME = HT * VT;
   localparam int CW  = 10;
   localparam bit POL = 1'b0;

   typedef struct packed {
      logic          de;
      logic          hsync;
      logic          vsync;
      logic          fs;
      logic          uf;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [23:0]   rgb;
   } out_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          pll_locked;
   logic          pix_req;
   logic          pix_valid;
   logic [23:0]   pix_data;
   logic          test_mode;
   logic [7:0]    vga_r, vga_g, vga_b;
   logic          hsync, vsync, de;
   logic [CW-1:0] x, y;
   logic          frame_start;
   logic          underflow;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POL(POL), .COORD_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pll_locked(pll_locked),
      .pix_req(pix_req),
      .pix_valid(pix_valid),
      .pix_data(pix_data),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b),
      .hsync(hsync),
      .vsync(vsync),
      .de(de),
      .x(x),
      .y(y),
      .frame_start(frame_start),
      .underflow(underflow)
   );

   // ---------------------------------------------------------------- queues
   bit          req_q [$];
   out_t        out_q [$];
   string       cname_q [$];
   logic [63:0] cgot_q [$];
   logic [63:0] cexp_q [$];

   int n_pass  = 0;
   int n_total = 0;
   bit mon_en   = 1'b0;
   bit stats_en = 1'b0;

   // Frame statistics gathered by the monitor from the DUT outputs
   int cyc = 0, fs_cyc = 0, fs_period = 0, frames_done = 0;
   int de_acc = 0, hs_acc = 0, vs_acc = 0;
   int frame_de = 0, frame_hs = 0, frame_vs = 0;
   bit fs_seen = 1'b0, saw_last = 1'b0;

   // ---------------------------------------------------------------- model
   int unsigned   t_m;          // cycles since run rose (0 while idle)
   bit            sync1_m, run_m, uf_m;
   logic [CW-1:0] lx_m, ly_m;
   logic [23:0]   bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   function automatic int model_h();
      return int'(t_m % HT);
   endfunction

   function automatic int model_v();
      return int'((t_m / HT) % VT);
   endfunction

   function automatic logic [23:0] pat_pix();
      logic [7:0] hb, vb;
      hb = 8'(model_h());
      vb = 8'(model_v());
      return {hb, vb, 8'hA5};
   endfunction

   task automatic push_chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      cname_q.push_back(name);
      cgot_q.push_back(got);
      cexp_q.push_back(exp);
   endtask

   // One clock of stimulus, plus the expectations for that cycle
   task automatic step(input bit lk, input bit pv, input logic [23:0] pd, input bit tm);
      int   h, v;
      bit   act, req;
      out_t e;
      @(negedge clk);
      pll_locked = lk;
      pix_valid  = pv;
      pix_data   = pd;
      test_mode  = tm;
      h   = model_h();
      v   = model_v();
      act = run_m && (h < HA) && (v < VA);
`ifdef VGA_TEST_PATTERN_EN
      req = act && !tm;
`else
      req = act;
`endif
      req_q.push_back(req);

      e = '0;
      e.hsync = ~POL;
      e.vsync = ~POL;
      if (run_m) begin
         e.de = act;
         if (act) begin
            lx_m = CW'(h);
            ly_m = CW'(v);
         end
         e.x = lx_m;
         e.y = ly_m;
         if (h >= HA + HFP && h < HA + HFP + HS) e.hsync = POL;
         if (v >= VA + VFP && v < VA + VFP + VS) e.vsync = POL;
         if (act && !req)     e.rgb = bars[h / (HA / 8)];
         else if (req && pv)  e.rgb = pd;
         if (req && !pv) uf_m = 1'b1;
         e.fs = req && (h == 0) && (v == 0);
      end else begin
         lx_m = '0;
         ly_m = '0;
      end
      e.uf = uf_m;
      out_q.push_back(e);

      t_m     = run_m ? t_m + 1 : 0;
      run_m   = sync1_m;
      sync1_m = lk;
   endtask

   task automatic do_reset();
      out_t r;
      mon_en = 1'b0;
      @(negedge clk);
      rst        = 1'b1;
      pll_locked = 1'b0;
      pix_valid  = 1'b0;
      test_mode  = 1'b0;
      @(negedge clk);
      r = '0;
      r.hsync = ~POL;
      r.vsync = ~POL;
      push_chk("reset_outputs", 64'({de, hsync, vsync, frame_start, underflow, x, y, vga_r, vga_g, vga_b}), 64'(r));
      push_chk("reset_pix_req", 64'(pix_req), 64'(0));
      req_q.delete();
      out_q.delete();
      t_m = 0; sync1_m = 0; run_m = 0; uf_m = 0; lx_m = '0; ly_m = '0;
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
   endtask

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      out_t        got, e;
      bit          eb;
      string       nm;
      logic [63:0] cg, ce;
      #2;
      while (cname_q.size() > 0) begin
         nm = cname_q.pop_front();
         cg = cgot_q.pop_front();
         ce = cexp_q.pop_front();
         n_total++;
         if (cg === ce) n_pass++;
         else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, cg, ce);
      end
      if (mon_en) begin
         if (req_q.size() > 0) begin
            eb = req_q.pop_front();
            n_total++;
            if (pix_req === eb) n_pass++;
            else $display("FAIL pix_req @%0t: got %b, expected %b", $time, pix_req, eb);
         end
         if (out_q.size() >= 2) begin
            e   = out_q.pop_front();
            got = {de, hsync, vsync, frame_start, underflow, x, y, vga_r, vga_g, vga_b};
            n_total++;
            if (got === e) n_pass++;
            else $display("FAIL cycle_outputs @%0t: got de=%b hs=%b vs=%b fs=%b uf=%b x=%0d y=%0d rgb=%h, expected de=%b hs=%b vs=%b fs=%b uf=%b x=%0d y=%0d rgb=%h",
                          $time, got.de, got.hsync, got.vsync, got.fs, got.uf, got.x, got.y, got.rgb,
                          e.de, e.hsync, e.vsync, e.fs, e.uf, e.x, e.y, e.rgb);
         end
      end
      if (stats_en) begin
         if (frame_start === 1'b1) begin
            if (fs_seen) begin
               fs_period = cyc - fs_cyc;
               frame_de  = de_acc;
               frame_hs  = hs_acc;
               frame_vs  = vs_acc;
               frames_done++;
            end
            fs_seen = 1'b1;
            fs_cyc  = cyc;
            de_acc  = 0;
            hs_acc  = 0;
            vs_acc  = 0;
         end
         if (de === 1'b1) de_acc++;
         if (hsync === POL) hs_acc++;
         if (vsync === POL) vs_acc++;
         if (de === 1'b1 && x == CW'(HA - 1) && y == CW'(VA - 1)) saw_last = 1'b1;
      end else begin
         fs_seen = 1'b0;
      end
      cyc++;
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int lat;
      bit found, dropped, seen;
      rst = 1'b1; pll_locked = 1'b0; pix_valid = 1'b0; pix_data = '0; test_mode = 1'b0;
      t_m = 0; sync1_m = 0; run_m = 0; uf_m = 0; lx_m = '0; ly_m = '0;

      // Reset, then 100 cycles without lock: everything must stay idle
      do_reset();
      repeat (100) step(1'b0, 1'b1, 24'($urandom()), 1'b0);

      // Lock: the first request comes 2 cycles after the lock edge
      step(1'b1, 1'b1, pat_pix(), 1'b0);
      lat = 0; found = 1'b0;
      for (int i = 1; i <= 8 && !found; i++) begin
         step(1'b1, 1'b1, pat_pix(), 1'b0);
         if (pix_req === 1'b1) begin found = 1'b1; lat = i; end
      end
      push_chk("first_req_latency", 64'(lat), 64'(2));

      // Two full frames of valid data, with frame statistics
      stats_en = 1'b1;
      repeat (2 * FRAME + 20) step(1'b1, 1'b1, pat_pix(), 1'b0);
      stats_en = 1'b0;
      push_chk("frames_measured", 64'(frames_done >= 1), 64'(1));
      push_chk("frame_period", 64'(fs_period), 64'(FRAME));
      push_chk("de_per_frame", 64'(frame_de), 64'(HA * VA));
      push_chk("hsync_per_frame", 64'(frame_hs), 64'(HS * VT));
      push_chk("vsync_per_frame", 64'(frame_vs), 64'(VS * HT));
      push_chk("last_pixel_seen", 64'(saw_last), 64'(1));

      // Underflow: drop the single request at (20,10)
      dropped = 1'b0;
      for (int i = 0; i < 2 * FRAME && !dropped; i++) begin
         if (run_m && model_h() == 20 && model_v() == 10) begin
            step(1'b1, 1'b0, pat_pix(), 1'b0);
            dropped = 1'b1;
         end else begin
            step(1'b1, 1'b1, pat_pix(), 1'b0);
         end
      end
      push_chk("underflow_drop_reached", 64'(dropped), 64'(1));
      step(1'b1, 1'b1, pat_pix(), 1'b0);
      push_chk("underflow_pixel", 64'({underflow, x, y, vga_r, vga_g, vga_b}),
               64'({1'b1, CW'(20), CW'(10), 24'h000000}));
      repeat (FRAME + 100) step(1'b1, 1'b1, pat_pix(), 1'b0);
      push_chk("underflow_sticky", 64'(underflow), 64'(1));

      // Lock loss at line 20
      for (int i = 0; i < FRAME && !(run_m && model_v() == 20 && model_h() == 30); i++)
         step(1'b1, 1'b1, pat_pix(), 1'b0);
      step(1'b0, 1'b1, pat_pix(), 1'b0);
      repeat (3) step(1'b0, 1'b1, pat_pix(), 1'b0);
      push_chk("lockloss_idle", 64'({de, hsync, vsync, x, y}),
               64'({1'b0, ~POL, ~POL, CW'(0), CW'(0)}));
      push_chk("lockloss_underflow_kept", 64'(underflow), 64'(1));
      repeat (10) step(1'b0, 1'b1, pat_pix(), 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(1'b1, 1'b1, pat_pix(), 1'b0);
         if (de === 1'b1) seen = 1'b1;
      end
      push_chk("relock_first_de", 64'(seen), 64'(1));
      if (seen) push_chk("relock_origin", 64'({frame_start, x, y}), 64'({1'b1, CW'(0), CW'(0)}));

      // Randomised data, valid gaps and short lock glitches
      repeat (FRAME + 200)
         step($urandom_range(0, 799) != 0, $urandom_range(0, 7) != 0, 24'($urandom()), 1'b0);

`ifdef VGA_TEST_PATTERN_EN
      // Colour bars: no requests, no underflow even with pix_valid low
      do_reset();
      repeat (FRAME + 50) step(1'b1, 1'b0, 24'($urandom()), 1'b1);
      push_chk("pattern_no_underflow", 64'(underflow), 64'(0));
      repeat (4 * HT) step(1'b1, 1'b1, 24'($urandom()), 1'($urandom_range(0, 1)));
      push_chk("pattern_mix_no_underflow", 64'(underflow), 64'(0));
`endif

      // Reset clears the sticky flag
      do_reset();
      repeat (2) step(1'b0, 1'b1, 24'($urandom()), 1'b0);
      @(negedge clk);
      #4;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
